sha3_absorb_buffer: RTL and testbench
=====================================

SHA3_ABSORB_BUFFER -- requirements
Module: sha3_absorb_buffer

Interface
REQ-001 SHALL have parameter DATAIN, default 64, input word width in bits; only 64 is supported.
REQ-002 SHALL have parameter RATE, default 1088, sponge rate in bits, which is 17 words or 136 bytes.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: input word is present.
REQ-006 SHALL have port in_ready, output, 1 bit: buffer accepts a word; transfer occurs when in_valid and in_ready are both high.
REQ-007 SHALL have port in_data, input, DATAIN bits: message bytes, byte k in bits [8k+7:8k].
REQ-008 SHALL have port in_last, input, 1 bit: this word ends the message.
REQ-009 SHALL have port in_bytes, input, 4 bits: valid bytes 0..8 in a last word; ignored (treated as 8) when in_last=0.
REQ-010 SHALL have port blk_valid, output, 1 bit: a padded rate block is presented to the permutation stage.
REQ-011 SHALL have port blk_ready, input, 1 bit: downstream consumes the block.
REQ-012 SHALL have port blk_data, output, RATE bits: word i in bits [64i+63:64i]; byte j in bits [8j+7:8j].
REQ-013 SHALL have port blk_last, output, 1 bit: the block is the final block of the message, so downstream squeezes the digest after it.

Function
REQ-014 SHALL implement FSM states FILL, PAD, HOLD and PADBLK, where PADBLK means a padding-only block is pending.
REQ-015 SHALL drive in_ready=1 only in FILL and only while rst=0.
REQ-016 In FILL, each transfer SHALL write the word to slot word_cnt (0..16) and increment word_cnt.
REQ-017 A transfer with in_last=0 into slot 16 SHALL go to HOLD with blk_last=0 and assert blk_valid on the next cycle.
REQ-018 A transfer with in_last=1 SHALL go to PAD, masking bytes at and above in_bytes in that word to zero.
REQ-019 PAD SHALL last exactly one cycle and apply SHA3 padding; pos = 8*slot + in_bytes.
REQ-020 In PAD, byte pos SHALL be XORed with 0x06, all bytes above pos zeroed, and byte 135 XORed with 0x80.
REQ-021 When pos=135, PAD SHALL make byte 135 equal 0x86.
REQ-022 When pos=136 (last word fills slot 16 with 8 bytes), PAD SHALL leave the block unpadded with blk_last=0 and move to HOLD, with PADBLK flagged.
REQ-023 The padding-only block SHALL have byte 0=0x06, byte 135=0x80, all other bytes 0, and blk_last=1.
REQ-024 Latency: blk_valid SHALL rise 1 cycle after the 17th non-last transfer, and 2 cycles after a last transfer (through PAD).
REQ-025 In HOLD, blk_valid=1 and blk_data/blk_last SHALL stay stable until blk_ready=1.
REQ-026 On a HOLD handshake, the buffer SHALL clear all slots and word_cnt, then go to PADBLK's block if flagged, otherwise to FILL.
REQ-027 A padding-only block SHALL itself pass through HOLD, then return to FILL.
REQ-028 No input SHALL be accepted while any block is held.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL set state=FILL, word_cnt=0, all slots 0, PADBLK flag 0, blk_valid=0 and blk_last=0; in_ready=0 while rst=1.
REQ-030 Reset mid-message or mid-HOLD SHALL discard all buffered data; no partial block is ever emitted.

Configuration
REQ-031 With SHA3_ABSORB_CNT_EN defined, the block SHALL add output msg_blocks [15:0], counting blocks handshaken in the current message, cleared by rst and on the handshake of a blk_last block, and saturating at 0xFFFF.
REQ-032 Without SHA3_ABSORB_CNT_EN, the port and counter SHALL be absent, with no other behavioural change.

Structure
REQ-033 Package sha3_pkg SHALL hold RATE_BYTES=136, LANES=17, DS_SHA3=8'h06, PAD_END=8'h80 and the FSM state enum.
REQ-034 A combinational sub-module sha3_pad_gen SHALL map pos and the pad-only flag to a 1088-bit pad XOR/zero mask.

Verification
REQ-035 Empty message: one word with in_last=1, in_bytes=0 -> one block with byte0=0x06, byte135=0x80, rest 0, blk_last=1.
REQ-036 "abc": in_data=0x636261, in_bytes=3, last -> bytes 0..2 = 61 62 63, byte3=0x06, byte135=0x80, blk_last=1.
REQ-037 135-byte message: 17 words, last in_bytes=7 -> single block with byte135=0x86, blk_last=1.
REQ-038 136-byte message: first block unpadded with blk_last=0, then pad-only block 06..80 with blk_last=1.
REQ-039 Backpressure: blk_ready=0 for 5 cycles in HOLD -> blk_data constant, in_ready=0, block taken on the 6th cycle.
REQ-040 Reset pulse after 5 words, then "abc" -> blk_valid stays 0 through reset, and the next block matches REQ-036 exactly.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared constants and FSM state encoding for the SHA3 absorb path.
package sha3_pkg;

  localparam int unsigned RATE_BYTES = 136;
  localparam int unsigned LANES      = 17;
  localparam logic [7:0]  DS_SHA3    = 8'h06;
  localparam logic [7:0]  PAD_END    = 8'h80;

  typedef enum logic [1:0] {
    StFill   = 2'd0,
    StPad    = 2'd1,
    StHold   = 2'd2,
    StPadBlk = 2'd3
  } sha3_state_e;

endpackage

// File: rtl/sha3_pad_gen.sv
// Builds the byte keep mask and XOR mask that turn a filled rate block into a SHA3-padded one.
module sha3_pad_gen
  import sha3_pkg::*;
(
  input  logic [7:0]              pos,
  input  logic                    pad_only,
  output logic [8*RATE_BYTES-1:0] keep_mask,
  output logic [8*RATE_BYTES-1:0] xor_mask,
  output logic                    no_pad
);

  always_comb begin
    keep_mask = '0;
    xor_mask  = '0;
    // A full 136-byte tail leaves no room; padding moves to a separate block.
    no_pad    = !pad_only && (pos >= 8'(RATE_BYTES));
    for (int j = 0; j < int'(RATE_BYTES); j++) begin
      if (no_pad || (!pad_only && j <= int'(pos))) begin
        keep_mask[8*j +: 8] = 8'hff;
      end
      if (!no_pad && ((pad_only && j == 0) || (!pad_only && j == int'(pos)))) begin
        xor_mask[8*j +: 8] = DS_SHA3;
      end
    end
    if (!no_pad) begin
      xor_mask[8*RATE_BYTES-1 -: 8] = xor_mask[8*RATE_BYTES-1 -: 8] ^ PAD_END;
    end
  end

endmodule

// File: rtl/sha3_absorb_buffer.sv
// Collects 64-bit message words into a 1088-bit rate block, applies SHA3 padding and hands blocks on.
// Optional SHA3_ABSORB_CNT_EN adds msg_blocks, a saturating per-message block counter.
module sha3_absorb_buffer
  import sha3_pkg::*;
#(
  parameter int unsigned DATAIN = 64,
  parameter int unsigned RATE   = 1088
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATAIN-1:0] in_data,
  input  logic              in_last,
  input  logic [3:0]        in_bytes,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [RATE-1:0]   blk_data,
  output logic              blk_last
`ifdef SHA3_ABSORB_CNT_EN
  ,
  output logic [15:0]       msg_blocks
`endif
);

  localparam logic [1:0] ST_FILL   = StFill;
  localparam logic [1:0] ST_PAD    = StPad;
  localparam logic [1:0] ST_HOLD   = StHold;
  localparam logic [1:0] ST_PADBLK = StPadBlk;

  logic [1:0]        state_q, state_d;
  logic [4:0]        word_cnt_q, word_cnt_d;
  logic [RATE-1:0]   buf_q, buf_d;
  logic [7:0]        pos_q, pos_d;
  logic              padblk_q, padblk_d;
  logic              last_q, last_d;
  logic [RATE-1:0]   keep_mask, xor_mask;
  logic              no_pad;
  logic [3:0]        nbytes;
  logic [DATAIN-1:0] word_masked;
  logic              in_fire, blk_fire;

  assign in_ready  = (state_q == ST_FILL) && !rst;
  assign in_fire   = in_valid && in_ready;
  assign blk_valid = (state_q == ST_HOLD) && !rst;
  assign blk_fire  = blk_valid && blk_ready;
  assign blk_data  = buf_q;
  assign blk_last  = last_q;

  always_comb begin
    nbytes = (!in_last || in_bytes > 4'd8) ? 4'd8 : in_bytes;
    word_masked = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < nbytes) word_masked[8*k +: 8] = in_data[8*k +: 8];
    end
  end

  sha3_pad_gen u_pad_gen (
    .pos       (pos_q),
    .pad_only  (state_q == ST_PADBLK),
    .keep_mask (keep_mask),
    .xor_mask  (xor_mask),
    .no_pad    (no_pad)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    buf_d      = buf_q;
    pos_d      = pos_q;
    padblk_d   = padblk_q;
    last_d     = last_q;
    unique case (state_q)
      ST_FILL: begin
        if (in_fire) begin
          for (int i = 0; i < int'(LANES); i++) begin
            if (word_cnt_q == 5'(i)) buf_d[DATAIN*i +: DATAIN] = word_masked;
          end
          word_cnt_d = word_cnt_q + 5'd1;
          pos_d      = {word_cnt_q, 3'b000} + {4'b0000, nbytes};
          if (in_last) begin
            state_d = ST_PAD;
          end else if (word_cnt_q == 5'(LANES - 1)) begin
            last_d  = 1'b0;
            state_d = ST_HOLD;
          end
        end
      end
      // Both the normal tail and the padding-only block go through the same mask.
      ST_PAD, ST_PADBLK: begin
        buf_d    = (buf_q & keep_mask) ^ xor_mask;
        padblk_d = no_pad;
        last_d   = !no_pad;
        state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        if (blk_fire) begin
          buf_d      = '0;
          word_cnt_d = '0;
          last_d     = 1'b0;
          state_d    = padblk_q ? ST_PADBLK : ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FILL;
      word_cnt_q <= '0;
      buf_q      <= '0;
      pos_q      <= '0;
      padblk_q   <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      buf_q      <= buf_d;
      pos_q      <= pos_d;
      padblk_q   <= padblk_d;
      last_q     <= last_d;
    end
  end

`ifdef SHA3_ABSORB_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (blk_fire) begin
      if (last_q) cnt_q <= '0;
      else if (cnt_q != 16'hffff) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign msg_blocks = cnt_q;
`endif

endmodule

// File: tb/tb_sha3_absorb_buffer.sv
// Directed bench for sha3_absorb_buffer: padding cases, backpressure, the pad-only block and reset.
module tb_sha3_absorb_buffer;

  localparam int RATE = 1088;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [63:0]     in_data;
  logic            in_last;
  logic [3:0]      in_bytes;
  logic            blk_valid;
  logic            blk_ready;
  logic [RATE-1:0] blk_data;
  logic            blk_last;
`ifdef SHA3_ABSORB_CNT_EN
  logic [15:0]     msg_blocks;
`endif

  int nvec  = 0;
  int nfail = 0;
  logic [RATE-1:0] exp_blk;
  logic [RATE-1:0] exp_abc;
  logic [RATE-1:0] exp_padonly;

  always #5 clk = ~clk;

  sha3_absorb_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last)
`ifdef SHA3_ABSORB_CNT_EN
    ,
    .msg_blocks (msg_blocks)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [RATE-1:0] exp);
    int bad;
    bad = -1;
    for (int j = 135; j >= 0; j--) begin
      if (blk_data[8*j +: 8] !== exp[8*j +: 8]) bad = j;
    end
    if (bad < 0) bad = 0;
    nvec++;
    assert (blk_data === exp) else begin
      nfail++;
      $error("FAIL %s: byte %0d observed %02h expected %02h", tag, bad,
             blk_data[8*bad +: 8], exp[8*bad +: 8]);
    end
  endtask

  // Message byte n (0-based) carries the value n+1.
  function automatic logic [63:0] msg_word(input int w);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = 8'(8*w + k + 1);
    return r;
  endfunction

  function automatic logic [RATE-1:0] msg_bytes(input int n);
    logic [RATE-1:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[8*j +: 8] = 8'(j + 1);
    return r;
  endfunction

  task automatic send(input logic [63:0] d, input logic last, input logic [3:0] nb);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    chk("in_ready_before_xfer", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bytes = 4'd0;
    in_data  = '0;
  endtask

  task automatic take;
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n;
    n = 0;
    @(negedge clk);
    while (!blk_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(blk_valid), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = 4'd0; blk_ready = 1'b0;

    exp_abc = '0;
    exp_abc[23:0]       = 24'h636261;
    exp_abc[31:24]      = 8'h06;
    exp_abc[RATE-1 -: 8] = 8'h80;
    exp_padonly = '0;
    exp_padonly[7:0]         = 8'h06;
    exp_padonly[RATE-1 -: 8] = 8'h80;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_blk_valid", 32'(blk_valid), 32'd0);
    chk("rst_blk_last", 32'(blk_last), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_blk_valid", 32'(blk_valid), 32'd0);

    // Empty message: valid only two cycles after the last transfer
    send(64'h0, 1'b1, 4'd0);
    @(negedge clk);
    chk("empty_pad_cycle_valid", 32'(blk_valid), 32'd0);
    @(negedge clk);
    chk("empty_valid", 32'(blk_valid), 32'd1);
    chk("empty_last", 32'(blk_last), 32'd1);
    chk_blk("empty_data", exp_padonly);
    take();
    @(negedge clk);
    chk("empty_after_valid", 32'(blk_valid), 32'd0);
    chk("empty_after_ready", 32'(in_ready), 32'd1);

    // "abc" with junk above in_bytes, then 5 cycles of backpressure
    send(64'hdead_beef_aa63_6261, 1'b1, 4'd3);
    @(negedge clk);
    @(negedge clk);
    chk("abc_valid", 32'(blk_valid), 32'd1);
    chk("abc_last", 32'(blk_last), 32'd1);
    chk_blk("abc_data", exp_abc);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_blk("abc_hold_data", exp_abc);
      chk("abc_hold_in_ready", 32'(in_ready), 32'd0);
      chk("abc_hold_valid", 32'(blk_valid), 32'd1);
    end
    take();
    @(negedge clk);
    chk("abc_taken_valid", 32'(blk_valid), 32'd0);

    // 135-byte message: pad lands on byte 135 -> 0x86
    for (int w = 0; w < 16; w++) send(msg_word(w), 1'b0, 4'd3);
    send(msg_word(16), 1'b1, 4'd7);
    @(negedge clk);
    @(negedge clk);
    exp_blk = msg_bytes(135);
    exp_blk[RATE-1 -: 8] = 8'h86;
    chk("m135_valid", 32'(blk_valid), 32'd1);
    chk("m135_last", 32'(blk_last), 32'd1);
    chk_blk("m135_data", exp_blk);
    take();

    // 17 non-last words: full block one cycle after the 17th transfer
    for (int w = 0; w < 17; w++) send(msg_word(w), 1'b0, 4'd3);
    @(negedge clk);
    chk("full_valid_lat1", 32'(blk_valid), 32'd1);
    chk("full_last", 32'(blk_last), 32'd0);
    chk_blk("full_data", msg_bytes(136));
    take();
    send(64'h0000_0000_0063_6261, 1'b1, 4'd3);
    @(negedge clk);
    @(negedge clk);
    chk_blk("full_then_abc_data", exp_abc);
    chk("full_then_abc_last", 32'(blk_last), 32'd1);
    take();

    // 136-byte message: unpadded block, then a padding-only block
    for (int w = 0; w < 16; w++) send(msg_word(w), 1'b0, 4'd8);
    send(msg_word(16), 1'b1, 4'd8);
    @(negedge clk);
    chk("m136_pad_cycle_valid", 32'(blk_valid), 32'd0);
    @(negedge clk);
    chk("m136_valid", 32'(blk_valid), 32'd1);
    chk("m136_last", 32'(blk_last), 32'd0);
    chk_blk("m136_data", msg_bytes(136));
`ifdef SHA3_ABSORB_CNT_EN
    chk("cnt_before", 32'(msg_blocks), 32'd0);
`endif
    take();
    @(negedge clk);
    chk("m136_gap_valid", 32'(blk_valid), 32'd0);
    chk("m136_gap_in_ready", 32'(in_ready), 32'd0);
`ifdef SHA3_ABSORB_CNT_EN
    chk("cnt_one", 32'(msg_blocks), 32'd1);
`endif
    wait_valid("padonly_valid", 4);
    chk("padonly_last", 32'(blk_last), 32'd1);
    chk_blk("padonly_data", exp_padonly);
    chk("padonly_in_ready", 32'(in_ready), 32'd0);
    take();
    @(negedge clk);
    chk("padonly_done_valid", 32'(blk_valid), 32'd0);
    chk("padonly_done_ready", 32'(in_ready), 32'd1);
`ifdef SHA3_ABSORB_CNT_EN
    chk("cnt_cleared", 32'(msg_blocks), 32'd0);
`endif

    // Reset after 5 words, then "abc"
    for (int w = 0; w < 5; w++) send(msg_word(w), 1'b0, 4'd8);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(blk_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_valid", 32'(blk_valid), 32'd0);
    send(64'h0000_0000_0063_6261, 1'b1, 4'd3);
    @(negedge clk);
    chk("postrst_pad_valid", 32'(blk_valid), 32'd0);
    @(negedge clk);
    chk_blk("postrst_abc_data", exp_abc);
    chk("postrst_abc_last", 32'(blk_last), 32'd1);

    // Reset while holding a block drops it
    rst = 1'b1;
    #1;
    chk("holdrst_valid", 32'(blk_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("holdrst_after_valid", 32'(blk_valid), 32'd0);
    chk("holdrst_after_last", 32'(blk_last), 32'd0);
    chk("holdrst_after_ready", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
